// File: rtl/apu_audio_filter.sv
// APU audio conditioning: box-car average over 2^WIN_LOG2 ce ticks, recentre
// to signed, optional one-pole DC-blocking high-pass, saturate, register.
module apu_audio_filter #(
  parameter int WIN_LOG2 = 5,
  parameter int DC_K     = 10,
  parameter int DC_BLOCK = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce,
  input  logic [15:0] sample_in,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        sample_valid
);

  localparam int AW = 16 + WIN_LOG2;

  // Stage A signals
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic [15:0]         avg;
  logic                va;

  // Stage B signals
  logic signed [15:0]  x;
  logic signed [15:0]  x_prev;
  logic signed [16:0]  dx;
  logic signed [34:0]  dx_scaled;
  logic signed [34:0]  y_acc;
  logic signed [34:0]  y_acc_nxt;
  logic signed [15:0]  y_byp;
  logic                vb;

  // Stage C signals
  logic signed [18:0]  y_full;
  logic [15:0]         y_clamp;

  assign acc_sum = acc + AW'(sample_in);

  // Stage A: accumulate one window; the last tick folds in its own sample and fires.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
      va  <= 1'b0;
    end else begin
      va <= 1'b0;
      if (ce) begin
        if (cnt == '1) begin
          avg <= acc_sum[AW-1:WIN_LOG2];
          acc <= '0;
          cnt <= '0;
          va  <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  // Flipping the MSB maps unsigned mid-scale 0x8000 to signed zero.
  assign x         = signed'(avg ^ 16'h8000);
  assign dx        = {x[15], x} - {x_prev[15], x_prev};
  assign dx_scaled = {{2{dx[16]}}, dx, 16'b0};
  assign y_acc_nxt = y_acc + dx_scaled - (y_acc >>> DC_K);

  // Stage B: high-pass update (16 fractional bits), or plain bypass.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      y_acc  <= '0;
      x_prev <= '0;
      y_byp  <= '0;
      vb     <= 1'b0;
    end else begin
      vb <= va;
      if (va) begin
        if (DC_BLOCK != 0) begin
          y_acc  <= y_acc_nxt;
          x_prev <= x;
        end else begin
          y_byp <= x;
        end
      end
    end
  end

  // Integer part of the filter (floor via the dropped fraction) and saturation.
  always_comb begin
    y_full  = '0;
    y_clamp = '0;
    if (DC_BLOCK != 0) begin
      y_full = y_acc[34:16];
    end else begin
      y_full = {{3{y_byp[15]}}, y_byp};
    end
    if (y_full > 19'sd32767) begin
      y_clamp = 16'h7FFF;
    end else if (y_full < -19'sd32768) begin
      y_clamp = 16'h8000;
    end else begin
      y_clamp = y_full[15:0];
    end
  end

  // Stage C: registered output held between updates; mute only gates the value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vb;
      if (vb) begin
        sample_out <= mute ? 16'h0000 : y_clamp;
      end
    end
  end

endmodule

// File: tb/tb_apu_audio_filter.sv
// Bench for apu_audio_filter: two instances (bypass and DC-blocking) driven in
// lockstep, compared every cycle against a window-level arithmetic model.
module tb_apu_audio_filter;

  localparam int WIN_LOG2 = 5;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int DC_K     = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ce = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] out0, out1;
  logic        v0, v1;

  always #5 clk = ~clk;

  apu_audio_filter #(.WIN_LOG2(WIN_LOG2), .DC_K(DC_K), .DC_BLOCK(0)) u_dc0 (
    .clk(clk), .resetn(resetn), .ce(ce), .sample_in(sample_in), .mute(mute),
    .sample_out(out0), .sample_valid(v0)
  );

  apu_audio_filter #(.WIN_LOG2(WIN_LOG2), .DC_K(DC_K), .DC_BLOCK(1)) u_dc1 (
    .clk(clk), .resetn(resetn), .ce(ce), .sample_in(sample_in), .mute(mute),
    .sample_out(out1), .sample_valid(v1)
  );

  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;

  // Reference model state
  int          win_q[$];
  longint      yacc;
  int          xp;
  longint      due_q[$];
  logic [15:0] val0_q[$];
  logic [15:0] val1_q[$];
  logic [15:0] e_o0, e_o1;
  logic        e_v;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] clamp16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // One clock edge of the model, using the inputs the DUT just sampled.
  task automatic model_edge();
    int     sum;
    int     avg;
    int     x;
    cyc++;
    if (!resetn) begin
      win_q.delete();
      yacc = 0;
      xp   = 0;
      due_q.delete();
      val0_q.delete();
      val1_q.delete();
      e_o0 = '0;
      e_o1 = '0;
      e_v  = 1'b0;
    end else begin
      e_v = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e_o0 = mute ? 16'h0000 : val0_q[0];
        e_o1 = mute ? 16'h0000 : val1_q[0];
        e_v  = 1'b1;
        void'(due_q.pop_front());
        void'(val0_q.pop_front());
        void'(val1_q.pop_front());
      end
      if (ce) begin
        win_q.push_back(int'(sample_in));
        if (win_q.size() == WIN) begin
          sum = 0;
          foreach (win_q[i]) sum += win_q[i];
          win_q.delete();
          avg  = sum / WIN;
          x    = avg - 32768;
          yacc = yacc + longint'(x - xp) * 65536 - (yacc >>> DC_K);
          xp   = x;
          due_q.push_back(cyc + 2);
          val0_q.push_back(clamp16(longint'(x)));
          val1_q.push_back(clamp16(yacc >>> 16));
        end
      end
    end
  endtask

  task automatic step(input logic c, input logic [15:0] s, input logic m, input logic r);
    ce = c;
    sample_in = s;
    mute = m;
    resetn = r;
    @(posedge clk);
    model_edge();
    #1;
    check_val("out_bypass", out0, e_o0);
    check_val("out_dcblk", out1, e_o1);
    check_val("valid_bypass", {15'b0, v0}, {15'b0, e_v});
    check_val("valid_dcblk", {15'b0, v1}, {15'b0, e_v});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic m);
    repeat (n) step(1'b0, 16'h0000, m, 1'b1);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic window(input logic [15:0] val, input int gap, input logic m);
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, val, m, 1'b1);
      repeat (gap) step(1'b0, val, m, 1'b1);
    end
  endtask

  initial begin
    // Ramp 0..31 into bypass, then back-to-back full-scale window
    do_reset(3);
    for (int i = 0; i < WIN; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    check_val("ramp_value", out0, 16'h800F);
    check_val("ramp_valid", {15'b0, v0}, 16'h0001);
    for (int i = 2; i < WIN; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    idle(2, 1'b0);
    check_val("fullscale_value", out0, 16'h7FFF);

    // DC step response
    do_reset(2);
    repeat (10) window(16'h8000, 0, 1'b0);
    check_val("dc_settled", out1, 16'h0000);
    window(16'h9000, 0, 1'b0);
    idle(2, 1'b0);
    check_val("step_first", out1, 16'd4096);
    window(16'h9000, 0, 1'b0);
    idle(2, 1'b0);
    check_val("step_second", out1, 16'd4092);

    // Saturation in both directions
    do_reset(2);
    repeat (3) window(16'h8000, 0, 1'b0);
    window(16'hFFFF, 0, 1'b0);
    idle(2, 1'b0);
    check_val("sat_pos", out1, 16'h7FFF);
    window(16'h0000, 0, 1'b0);
    idle(2, 1'b0);
    check_val("sat_neg", out1, 16'h8000);

    // Sparse ce: one tick every third cycle
    do_reset(2);
    window(16'hC000, 2, 1'b0);
    window(16'hC000, 2, 1'b0);
    idle(2, 1'b0);
    check_val("gap_value", out0, 16'h4000);

    // Mute while the filter decays, then release
    do_reset(2);
    repeat (10) window(16'h8000, 0, 1'b0);
    repeat (3) window(16'h9000, 0, 1'b1);
    idle(2, 1'b1);
    check_val("muted_out", out1, 16'h0000);
    window(16'h9000, 0, 1'b0);
    idle(2, 1'b0);
    check_val("unmuted_decayed", out1, 16'd4084);

    // Reset mid-window and right after a window completes
    do_reset(2);
    for (int i = 0; i < 16; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    window(16'h1234, 0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    idle(4, 1'b0);
    check_val("aborted_out", out0, 16'h0000);
    window(16'hA000, 0, 1'b0);
    idle(2, 1'b0);
    check_val("post_reset_value", out0, 16'h2000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] s;
      case ($urandom_range(0, 3))
        0: s = 16'h0000;
        1: s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), s, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 499) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
